// File: rtl/time_disp_pkg.sv
// Shared constants, FSM state type and segment decode for the time display scanner.
package time_disp_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int NUM_FIELDS = 3;
  localparam int BIN_W      = 6;
  localparam int CONV_STEPS = 6;

  // Digit positions on the display, right to left.
  localparam logic [2:0] IDX_SECS_ONES  = 3'd0;
  localparam logic [2:0] IDX_SECS_TENS  = 3'd1;
  localparam logic [2:0] IDX_MINS_ONES  = 3'd2;
  localparam logic [2:0] IDX_MINS_TENS  = 3'd3;
  localparam logic [2:0] IDX_HOURS_ONES = 3'd4;
  localparam logic [2:0] IDX_HOURS_TENS = 3'd5;

  localparam int FIELD_SECS  = 0;
  localparam int FIELD_MINS  = 1;
  localparam int FIELD_HOURS = 2;

  localparam logic [5:0] HOURS_MAX = 6'd23;
  localparam logic [5:0] MINS_MAX  = 6'd59;
  localparam logic [5:0] SECS_MAX  = 6'd59;

  // Active-low {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic logic [5:0] field_max(input int field);
    case (field)
      FIELD_HOURS: field_max = HOURS_MAX;
      FIELD_MINS:  field_max = MINS_MAX;
      default:     field_max = SECS_MAX;
    endcase
  endfunction

  // Nibble F marks an out-of-range field and shows as a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      4'hF:    seg_decode = SEG_DASH;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/time_display_scan_bin2bcd_seq.sv
// Serial double-dabble: load on start, one add-3/shift per step, done the cycle after the last step.
module bin2bcd_seq
  import time_disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic             last,
  input  logic [BIN_W-1:0] value,
  output logic [7:0]       bcd,
  output logic             done
);

  logic [BIN_W-1:0] shift_reg;
  logic [7:0]       adj;

  always_comb begin
    adj = bcd;
    if (bcd[3:0] >= 4'd5) adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bcd       <= '0;
      done      <= 1'b0;
    end else begin
      done <= step & last;
      if (start) begin
        shift_reg <= value;
        bcd       <= '0;
      end else if (step) begin
        bcd       <= {adj[6:0], shift_reg[BIN_W-1]};
        shift_reg <= {shift_reg[BIN_W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/time_display_scan.sv
// Multiplexed 6-digit 7-segment driver: per-frame time snapshot, serial BCD conversion, alarm blink.
module time_display_scan
  import time_disp_pkg::*;
#(
  parameter int DIGIT_DWELL = 125000,
  parameter int BLINK_HALF  = 62500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  hours,
  input  logic [5:0]  mins,
  input  logic [5:0]  secs,
  input  logic        alarm,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [23:0] bcd_time,
  output logic        frame_upd
);

  localparam int DW = $clog2(DIGIT_DWELL);
  localparam int BW = $clog2(BLINK_HALF + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DIGIT_DWELL - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [2:0]    STEP_LAST  = 3'(CONV_STEPS - 1);

  logic [DW-1:0] dwell_reg;
  logic [2:0]    index_reg;
  logic          first_reg;
  logic [BW-1:0] blink_cnt_reg;
  logic          blink_reg;
  state_t        state_reg, state_next;
  logic [2:0]    step_reg, step_next;
  logic          load, step_en, commit;

  logic             dwell_term, frame_start;
  logic [BIN_W-1:0] field_bin  [NUM_FIELDS];
  logic [BIN_W-1:0] field_snap_reg [NUM_FIELDS];
  logic [7:0]       field_bcd  [NUM_FIELDS];
  logic [NUM_FIELDS-1:0] field_done;
  logic [23:0]      commit_val;
  logic [3:0]       digit [NUM_DIGITS];
  logic [3:0]       cur_digit;

  assign dwell_term  = (dwell_reg == DWELL_LAST);
  // first_reg stays set until the first edge after reset, which starts the first frame.
  assign frame_start = first_reg | (dwell_term & (index_reg == IDX_HOURS_TENS));

  assign field_bin[FIELD_SECS]  = secs;
  assign field_bin[FIELD_MINS]  = mins;
  assign field_bin[FIELD_HOURS] = {1'b0, hours};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_reg     <= '0;
      index_reg     <= '0;
      first_reg     <= 1'b1;
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
    end else begin
      first_reg <= 1'b0;
      dwell_reg <= dwell_term ? '0 : dwell_reg + 1'b1;
      if (dwell_term)
        index_reg <= (index_reg == IDX_HOURS_TENS) ? IDX_SECS_ONES : index_reg + 3'd1;
      if (!alarm) begin
        blink_cnt_reg <= '0;
        blink_reg     <= 1'b0;
      end else if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg <= '0;
        blink_reg     <= ~blink_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    load       = 1'b0;
    step_en    = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: if (frame_start) begin
        load       = 1'b1;
        step_next  = '0;
        state_next = CONV;
      end
      CONV: begin
        step_en   = 1'b1;
        step_next = step_reg + 3'd1;
        if (step_reg == STEP_LAST) state_next = COMMIT;
      end
      COMMIT: begin
        commit     = &field_done;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (load),
        .step  (step_en),
        .last  (step_reg == STEP_LAST),
        .value (field_bin[gi]),
        .bcd   (field_bcd[gi]),
        .done  (field_done[gi])
      );

      always_ff @(posedge clk or posedge reset) begin
        if (reset)     field_snap_reg[gi] <= '0;
        else if (load) field_snap_reg[gi] <= field_bin[gi];
      end

      assign commit_val[gi*8 +: 8] =
        (field_snap_reg[gi] > field_max(gi)) ? 8'hFF : field_bcd[gi];
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit[gi] = bcd_time[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_time  <= '0;
      frame_upd <= 1'b0;
    end else begin
      frame_upd <= commit;
      if (commit) bcd_time <= commit_val;
    end
  end

  assign cur_digit = digit[index_reg];

  always_comb begin
    an  = '1;
    seg = SEG_BLANK;
    dp  = 1'b1;
    if (!first_reg) begin
      seg = seg_decode(cur_digit);
      if (!blink_reg) an = ~(6'd1 << index_reg);
      if ((index_reg == IDX_MINS_ONES || index_reg == IDX_HOURS_ONES) &&
          !field_snap_reg[FIELD_SECS][0])
        dp = 1'b0;
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Directed bench for time_display_scan with a frame-start scoreboard on bcd_time/frame_upd.
module tb_time_display_scan;

  localparam int DWELL = 4;
  localparam int BLINK = 16;
  localparam int FRAME = 6 * DWELL;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  hours = '0;
  logic [5:0]  mins = '0;
  logic [5:0]  secs = '0;
  logic        alarm = 1'b0;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [23:0] bcd_time;
  logic        frame_upd;

  int checks = 0;
  int errors = 0;

  time_display_scan #(.DIGIT_DWELL(DWELL), .BLINK_HALF(BLINK)) dut (
    .clk       (clk),
    .reset     (reset),
    .hours     (hours),
    .mins      (mins),
    .secs      (secs),
    .alarm     (alarm),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .bcd_time  (bcd_time),
    .frame_upd (frame_upd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fld(input int v, input int lim);
    if (v > lim) return 8'hFF;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Scoreboard: expected commit pushed at each predicted frame-start edge.
  typedef struct { logic [23:0] val; int e; } exp_t;
  exp_t exp_q[$];
  exp_t got;
  int   edge_cnt = 0;

  always @(posedge clk) begin
    if (reset) begin
      exp_q.delete();
      edge_cnt <= 0;
    end else begin
      if (edge_cnt == 0 || edge_cnt % FRAME == FRAME - 1)
        exp_q.push_back('{{fld(int'(hours), 23), fld(int'(mins), 59), fld(int'(secs), 59)}, edge_cnt});
      edge_cnt <= edge_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (!reset && frame_upd === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("upd_unexpected", frame_upd, 0);
      end else begin
        got = exp_q.pop_front();
        check("sb_bcd_time", bcd_time, got.val);
        check("sb_latency", edge_cnt - 1 - got.e, 7);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_upd(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (frame_upd !== 1'b1 && cyc < 64);
    check("upd_timeout", frame_upd, 1);
  endtask

  task automatic wait_index(input int i);
    logic [5:0] want;
    int n;
    want = ~(6'd1 << i);
    n = 0;
    while (an !== want && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("idx_timeout", an, want);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // Reset held
    tick(3);
    check("rst_an", an, 6'h3F);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_bcd", bcd_time, 0);
    check("rst_upd", frame_upd, 0);
    reset = 1'b0;
    tick(1);
    check("idx0_an", an, 6'b111110);
    check("idx0_seg", seg, 7'b1000000);
    tick(-1 + 1);
    cyc = 1;
    wait_upd(cyc);
    check("rel_latency", cyc, 7);
    check("rel_bcd", bcd_time, 0);

    // 23:59:58
    hours = 5'd23; mins = 6'd59; secs = 6'd58;
    wait_upd(cyc);
    check("t1_bcd", bcd_time, 24'h235958);
    wait_index(5);
    check("t1_seg5", seg, 7'b0100100);
    wait_index(0);
    check("t1_seg0", seg, 7'b0000000);
    tick(DWELL);
    check("t1_an1", an, 6'b111101);
    check("t1_seg1", seg, 7'b0010010);
    tick(DWELL);
    check("t1_an2", an, 6'b111011);
    check("t1_dp2", dp, 0);
    tick(DWELL);
    check("t1_dp3", dp, 1);
    tick(DWELL);
    check("t1_dp4", dp, 0);

    // secs 10 -> 11 mid-frame
    secs = 6'd10;
    wait_upd(cyc);
    check("t2_bcd10", bcd_time, 24'h235910);
    wait_index(3);
    secs = 6'd11;
    check("t2_hold_idx3", bcd_time[3:0], 0);
    wait_index(5);
    check("t2_hold_idx5", bcd_time[3:0], 0);
    wait_upd(cyc);
    check("t2_bcd11", bcd_time, 24'h235911);
    wait_index(2);
    check("t2_dp2_odd", dp, 1);
    wait_index(4);
    check("t2_dp4_odd", dp, 1);

    // out of range
    hours = 5'd24; mins = 6'd60; secs = 6'd5;
    wait_upd(cyc);
    check("t3_bcd", bcd_time, 24'hFFFF05);
    wait_index(2);
    check("t3_seg2", seg, 7'b0111111);
    check("t3_dp2", dp, 1);
    tick(DWELL);
    check("t3_seg3", seg, 7'b0111111);
    tick(DWELL);
    check("t3_seg4", seg, 7'b0111111);
    tick(DWELL);
    check("t3_seg5", seg, 7'b0111111);
    tick(DWELL);
    check("t3_seg0", seg, 7'b0010010);

    // alarm blink
    alarm = 1'b1;
    for (int j = 1; j <= 63; j++) begin
      tick(1);
      if (((j >> 4) & 1) == 1) check("blink_off", an, 6'h3F);
      else check("blink_on", (an !== 6'h3F), 1);
    end
    alarm = 1'b0;
    tick(1);
    check("alarm_clr_on", (an !== 6'h3F), 1);
    alarm = 1'b1;
    for (int j = 1; j <= BLINK; j++) begin
      tick(1);
      if (j < BLINK) check("rearm_on", (an !== 6'h3F), 1);
      else check("rearm_off", an, 6'h3F);
    end
    alarm = 1'b0;

    // reset during conversion
    hours = 5'd12; mins = 6'd34; secs = 6'd56;
    wait_index(5);
    wait_index(0);
    tick(3);
    reset = 1'b1;
    #1;
    check("conv_rst_an", an, 6'h3F);
    check("conv_rst_seg", seg, 7'h7F);
    check("conv_rst_dp", dp, 1);
    check("conv_rst_bcd", bcd_time, 0);
    check("conv_rst_upd", frame_upd, 0);
    tick(2);
    reset = 1'b0;
    wait_upd(cyc);
    check("conv_rel_latency", cyc, 8);
    check("conv_rel_bcd", bcd_time, 24'h123456);
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_display_scan.md
Name: time_display_scan

Overview:
- Display-side consumer of the real-time clock's binary hours/mins/secs/buzzer outputs.
- Snapshots the time once per scan frame and converts each field to two BCD digits with a sequential double-dabble.
- Drives a 6-digit multiplexed, active-low 7-segment display.
- Blinks the whole display while the alarm is active.

Parameters:
- DIGIT_DWELL, 125000, clk cycles each digit stays enabled (1 ms at 125 MHz); must be >= 2.
- BLINK_HALF, 62500000, clk cycles per blink half-period while alarm is high (0.5 s).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- hours  input  5  binary hours from clock, valid range 0-23.
- mins  input  6  binary minutes, valid range 0-59.
- secs  input  6  binary seconds, valid range 0-59.
- alarm  input  1  buzzer level from clock.
- an  output  6  digit enables, active-low one-hot; bit0 = secs ones ... bit5 = hours tens.
- seg  output  7  segments, active-low, order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- bcd_time  output  24  committed display value {hT,hO,mT,mO,sT,sO}, 4 bits each.
- frame_upd  output  1  one-cycle pulse when bcd_time is updated.

Behaviour:
- Reset (async) values: an=6'b111111, seg=7'b1111111, dp=1, bcd_time=0, frame_upd=0, digit index=0, dwell/blink counters=0, blink phase=0, FSM=IDLE.
- Reset asserted mid-conversion aborts the conversion. No partial commit.
- Scan:
  - Dwell counter counts 0..DIGIT_DWELL-1. At the terminal count the digit index advances 0..5 and wraps 5->0.
  - an = ~(1<<index). seg shows the committed digit for the current index.
- Frame start:
  - Occurs on the 5->0 wrap, and on the first clk edge after reset release.
  - On frame start, if FSM=IDLE, latch hours/mins/secs into snapshot registers and enter CONV.
  - Inputs are not sampled at any other time, so an input change mid-frame never tears the display.
- FSM:
  - IDLE -> CONV on frame start.
  - CONV runs exactly 6 cycles. Each cycle, add 3 to any BCD nibble >= 5, then shift left, bringing in the next snapshot MSB. All three fields are converted in parallel.
  - CONV -> COMMIT. COMMIT writes bcd_time and pulses frame_upd, then returns to IDLE.
  - Latency: snapshot edge to bcd_time update = 7 cycles; frame_upd is high on the 7th.
- Range check (evaluated on the snapshot):
  - hours > 23, or mins > 59, or secs > 59 -> both digits of that field display dash 7'b0111111.
  - bcd_time for that field holds 4'hF,4'hF.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Leading zeros are displayed, not blanked.
- dp:
  - Low on index 2 and index 4 (field separators) when snapshot secs is even; otherwise high.
  - High on all other indices.
- Blink:
  - While alarm=1, the blink counter counts 0..BLINK_HALF-1 and toggles blink phase at the terminal count.
  - Phase 1 forces an=6'b111111. Scan and conversion continue unaffected.
  - alarm=0 holds counter=0 and phase=0.
  - A rising alarm therefore starts with the display on.
- Simultaneous events: a frame start while FSM is not IDLE is ignored; the snapshot is taken at the next frame start.
  - Cannot occur when DIGIT_DWELL >= 2, since 6*DIGIT_DWELL >= 12 > 8.

Decomposition:
- Package time_disp_pkg holds:
  - segment code constants (digits 0-9, dash, blank);
  - digit index constants;
  - FSM state enum {IDLE, CONV, COMMIT};
  - field range limits 23/59.
- Sub-module bin2bcd_seq: 6-bit serial double-dabble with start/done, instantiated three times and sharing the top FSM's step count.

Test Plan (DIGIT_DWELL=4, BLINK_HALF=16):
- Reset held, then released with inputs 0:
  - During reset: an=111111, seg=1111111.
  - frame_upd pulses 7 cycles after release; bcd_time=0.
  - Index 0 shows seg=1000000.
- hours=23, mins=59, secs=58:
  - After next commit, bcd_time=24'h235958.
  - an steps 111110,111101,111011,... every 4 cycles.
  - Index 5 seg=0100100, index 0 seg=0000000.
  - dp low on index 2/4.
- secs changes 10->11 while index=3:
  - bcd_time sO stays 0 until 7 cycles after the next 5->0 wrap, then becomes 1.
  - dp goes high on index 2/4.
- hours=24, mins=60, secs=5:
  - Indices 5,4,3,2 show 0111111.
  - bcd_time=24'hFFFF05.
- alarm=1 for 64 cycles:
  - an forced 111111 for cycles 16-31 and 48-63, scanning otherwise.
  - alarm->0 resumes scan on the next cycle with phase 0.
- reset pulsed during CONV:
  - Outputs return immediately to reset values.
  - No frame_upd until 7 cycles after release.
  - bcd_time then reflects current inputs.
